gun_sensor_decoder: RTL and testbench

Converts the light-gun sensor pulse back into the 6-bit gun_h/gun_v coordinates the Williams2 board consumes. This is the receive end of the lightgun crosshair/sensor path. The block tracks the beam position from HDE/VDE/CE_PIX and latches the beam counters on the first sensor edge of each active frame. At end of frame it compensates the sensor delay, scales, clamps, smooths and publishes the position. It sits in the top level between the lightgun SENSOR output and the williams2 gun_h/gun_v inputs, replacing the joystick-stepped path when a lightgun mode is selected.

---
 rtl/gun_sensor_decoder.sv | 151 +++++++++++++++
 tb/tb_gun_sensor_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gun_sensor_decoder.sv
// Light-gun receive path: tracks the beam from HDE/VDE/CE_PIX, latches it on the first
// sensor edge of a frame and publishes a delay-compensated, scaled, smoothed GUN_H/GUN_V.
module gun_sensor_decoder #(
   parameter int SENSOR_DELAY = 34,
   parameter int H_SHIFT      = 2,
   parameter int V_SHIFT      = 2,
   parameter int MISS_FRAMES  = 4
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CE_PIX,
   input  logic       HDE,
   input  logic       VDE,
   input  logic       SENSOR,
   output logic [5:0] GUN_H,
   output logic [5:0] GUN_V,
   output logic       VALID,
   output logic       HIT
);

   localparam logic [8:0] DELAY      = 9'(SENSOR_DELAY);
   localparam logic [3:0] MISS_LIMIT = 4'(MISS_FRAMES);

   typedef enum logic [1:0] {WAIT_FRAME, ARMED, CAPTURED, UPDATE} state_t;

   state_t     state, state_next;
   logic       hde_r, vde_r, sns_r, vde_low_seen;
   logic       line_start, line_end, frame_start, frame_end, sensor_edge;
   logic       capture;
   logic       hit_frame;
   logic [8:0] hcnt, vcnt, cap_h, cap_v;
   logic [8:0] h_comp, h_scaled, v_scaled;
   logic [5:0] s_h, s_v, avg_h, avg_v;
   logic [3:0] miss_cnt, miss_next;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hde_r        <= 1'b0;
         vde_r        <= 1'b0;
         sns_r        <= 1'b0;
         vde_low_seen <= 1'b0;
      end else begin
         hde_r        <= HDE;
         vde_r        <= VDE;
         sns_r        <= SENSOR;
         vde_low_seen <= vde_low_seen | ~VDE;
      end
   end

   // A reset released while VDE is high must not look like a frame start,
   // otherwise the tail of a partial frame could be sampled.
   assign line_start  = HDE & ~hde_r;
   assign line_end    = ~HDE & hde_r;
   assign frame_start = VDE & ~vde_r & vde_low_seen;
   assign frame_end   = ~VDE & vde_r;
   assign sensor_edge = SENSOR & ~sns_r;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         if (line_start)
            hcnt <= '0;
         else if (CE_PIX && HDE && hcnt != 9'd511)
            hcnt <= hcnt + 9'd1;
         if (frame_start)
            vcnt <= '0;
         else if (line_end && VDE && vcnt != 9'd511)
            vcnt <= vcnt + 9'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         state <= WAIT_FRAME;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         WAIT_FRAME: if (frame_start) state_next = ARMED;
         ARMED: begin
            if (frame_end)
               state_next = UPDATE;
            else if (sensor_edge && HDE && VDE) begin
               capture    = 1'b1;
               state_next = CAPTURED;
            end
         end
         CAPTURED:   if (frame_end) state_next = UPDATE;
         UPDATE:     state_next = WAIT_FRAME;
         default:    state_next = WAIT_FRAME;
      endcase
   end

   // hit_frame remembers whether UPDATE was entered from CAPTURED.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cap_h     <= '0;
         cap_v     <= '0;
         hit_frame <= 1'b0;
      end else begin
         if (capture) begin
            cap_h     <= hcnt;
            cap_v     <= vcnt;
            hit_frame <= 1'b1;
         end else if (state == UPDATE) begin
            hit_frame <= 1'b0;
         end
      end
   end

   assign h_comp    = (cap_h >= DELAY) ? (cap_h - DELAY) : 9'd0;
   assign h_scaled  = h_comp >> H_SHIFT;
   assign v_scaled  = cap_v >> V_SHIFT;
   assign s_h       = (h_scaled > 9'd63) ? 6'd63 : h_scaled[5:0];
   assign s_v       = (v_scaled > 9'd63) ? 6'd63 : v_scaled[5:0];
   assign avg_h     = 6'(({1'b0, GUN_H} + {1'b0, s_h} + 7'd1) >> 1);
   assign avg_v     = 6'(({1'b0, GUN_V} + {1'b0, s_v} + 7'd1) >> 1);
   assign miss_next = (miss_cnt == 4'd15) ? 4'd15 : miss_cnt + 4'd1;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         GUN_H    <= 6'd32;
         GUN_V    <= 6'd32;
         VALID    <= 1'b0;
         HIT      <= 1'b0;
         miss_cnt <= '0;
      end else begin
         HIT <= 1'b0;
         if (state == UPDATE) begin
            if (hit_frame) begin
               GUN_H    <= VALID ? avg_h : s_h;
               GUN_V    <= VALID ? avg_v : s_v;
               VALID    <= 1'b1;
               HIT      <= 1'b1;
               miss_cnt <= '0;
            end else begin
               miss_cnt <= miss_next;
               if (miss_next >= MISS_LIMIT)
                  VALID <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_gun_sensor_decoder.sv
// Directed bench for gun_sensor_decoder: builds frames line by line with CE_PIX always high
// and checks the published position against hand-computed values.
module tb_gun_sensor_decoder;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b1;
   logic       CE_PIX = 1'b1;
   logic       HDE = 1'b0;
   logic       VDE = 1'b0;
   logic       SENSOR = 1'b0;
   logic [5:0] GUN_H, GUN_V;
   logic       VALID, HIT;

   int checks = 0;
   int errors = 0;
   int hit_count = 0;

   gun_sensor_decoder dut (
      .CLK(CLK), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .HDE(HDE), .VDE(VDE),
      .SENSOR(SENSOR), .GUN_H(GUN_H), .GUN_V(GUN_V), .VALID(VALID), .HIT(HIT)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (HIT === 1'b1) hit_count++;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Line with HDE high; the sensor edge sees hcnt == h1 (and h2) because hcnt
   // is cleared one cycle into the line and then counts every clock.
   task automatic run_line(input int h1, input int h2);
      int len;
      len = (h1 < 0) ? 4 : (((h2 > h1) ? h2 : h1) + 4);
      HDE = 1'b1;
      for (int i = 0; i < len; i++) begin
         SENSOR = ((h1 >= 0) && (i == h1 + 1)) || ((h2 >= 0) && (i == h2 + 1));
         tick();
      end
      HDE = 1'b0;
      SENSOR = 1'b0;
      tick();
      tick();
   endtask

   // Full frame; returns at the sample point, 2 clocks after VDE falls.
   task automatic run_frame(input int sens_line, input int h1, input int h2, input int nlines);
      VDE = 1'b1;
      tick();
      tick();
      for (int l = 0; l < nlines; l++) begin
         if (l == sens_line) run_line(h1, h2);
         else run_line(-1, -1);
      end
      VDE = 1'b0;
      tick();
      tick();
   endtask

   task automatic vblank(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset;
      #1 RESET_N = 1'b0;
      #1;
      checks++; if (GUN_H !== 6'd32) begin errors++; $display("[TB] FAIL reset gun_h got %0d want 32", GUN_H); end
      checks++; if (GUN_V !== 6'd32) begin errors++; $display("[TB] FAIL reset gun_v got %0d want 32", GUN_V); end
      checks++; if (VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset valid got %b want 0", VALID); end
      checks++; if (HIT !== 1'b0) begin errors++; $display("[TB] FAIL reset hit got %b want 0", HIT); end
      vblank(3);
      RESET_N = 1'b1;
      vblank(3);
   endtask

   task automatic test_first_hit;
      int hc0;
      hc0 = hit_count;
      run_frame(100, 134, -1, 102);
      checks++; if (HIT !== 1'b1) begin errors++; $display("[TB] FAIL first_hit hit got %b want 1", HIT); end
      checks++; if (GUN_H !== 6'd25) begin errors++; $display("[TB] FAIL first_hit gun_h got %0d want 25", GUN_H); end
      checks++; if (GUN_V !== 6'd25) begin errors++; $display("[TB] FAIL first_hit gun_v got %0d want 25", GUN_V); end
      checks++; if (VALID !== 1'b1) begin errors++; $display("[TB] FAIL first_hit valid got %b want 1", VALID); end
      tick();
      checks++; if (HIT !== 1'b0) begin errors++; $display("[TB] FAIL first_hit hit_fall got %b want 0", HIT); end
      vblank(3);
      checks++; if (hit_count - hc0 !== 1) begin errors++; $display("[TB] FAIL first_hit pulse_len got %0d want 1", hit_count - hc0); end
   endtask

   task automatic test_smoothing;
      run_frame(200, 234, -1, 202);
      checks++; if (GUN_H !== 6'd38) begin errors++; $display("[TB] FAIL smoothing gun_h got %0d want 38", GUN_H); end
      checks++; if (GUN_V !== 6'd38) begin errors++; $display("[TB] FAIL smoothing gun_v got %0d want 38", GUN_V); end
      checks++; if (HIT !== 1'b1) begin errors++; $display("[TB] FAIL smoothing hit got %b want 1", HIT); end
      vblank(4);
   endtask

   task automatic test_boundaries;
      // hcnt 20 compensates below zero: s_h=0, s_v=25 -> (38+0+1)>>1, (38+25+1)>>1
      run_frame(100, 20, -1, 102);
      checks++; if (GUN_H !== 6'd19) begin errors++; $display("[TB] FAIL bound_low gun_h got %0d want 19", GUN_H); end
      checks++; if (GUN_V !== 6'd32) begin errors++; $display("[TB] FAIL bound_low gun_v got %0d want 32", GUN_V); end
      vblank(4);
      // both clamp to 63 -> (19+63+1)>>1, (32+63+1)>>1
      run_frame(300, 400, -1, 302);
      checks++; if (GUN_H !== 6'd41) begin errors++; $display("[TB] FAIL bound_clamp gun_h got %0d want 41", GUN_H); end
      checks++; if (GUN_V !== 6'd48) begin errors++; $display("[TB] FAIL bound_clamp gun_v got %0d want 48", GUN_V); end
      vblank(4);
   endtask

   task automatic test_double_sensor;
      run_frame(100, 134, 300, 102);
      checks++; if (GUN_H !== 6'd33) begin errors++; $display("[TB] FAIL double gun_h got %0d want 33", GUN_H); end
      checks++; if (GUN_V !== 6'd37) begin errors++; $display("[TB] FAIL double gun_v got %0d want 37", GUN_V); end
      vblank(4);
   endtask

   task automatic test_blank_sensor;
      int hc0;
      hc0 = hit_count;
      SENSOR = 1'b1; tick(); SENSOR = 1'b0; tick();
      VDE = 1'b1;
      tick(); tick();
      run_line(-1, -1);
      SENSOR = 1'b1; tick(); SENSOR = 1'b0; tick();
      run_line(-1, -1);
      VDE = 1'b0;
      tick(); tick();
      vblank(3);
      checks++; if (hit_count !== hc0) begin errors++; $display("[TB] FAIL blank hits got %0d want %0d", hit_count, hc0); end
      checks++; if (VALID !== 1'b1) begin errors++; $display("[TB] FAIL blank valid got %b want 1", VALID); end
      checks++; if (GUN_H !== 6'd33) begin errors++; $display("[TB] FAIL blank gun_h got %0d want 33", GUN_H); end
      checks++; if (GUN_V !== 6'd37) begin errors++; $display("[TB] FAIL blank gun_v got %0d want 37", GUN_V); end
   endtask

   task automatic test_miss;
      int hc0;
      run_frame(100, 134, -1, 102);
      checks++; if (GUN_H !== 6'd29) begin errors++; $display("[TB] FAIL miss_prehit gun_h got %0d want 29", GUN_H); end
      checks++; if (GUN_V !== 6'd31) begin errors++; $display("[TB] FAIL miss_prehit gun_v got %0d want 31", GUN_V); end
      vblank(4);
      hc0 = hit_count;
      for (int f = 1; f <= 4; f++) begin
         run_frame(-1, -1, -1, 4);
         checks++;
         if (VALID !== ((f < 4) ? 1'b1 : 1'b0)) begin
            errors++; $display("[TB] FAIL miss_frame%0d valid got %b want %b", f, VALID, (f < 4));
         end
         vblank(4);
      end
      checks++; if (GUN_H !== 6'd29) begin errors++; $display("[TB] FAIL miss gun_h got %0d want 29", GUN_H); end
      checks++; if (GUN_V !== 6'd31) begin errors++; $display("[TB] FAIL miss gun_v got %0d want 31", GUN_V); end
      checks++; if (hit_count !== hc0) begin errors++; $display("[TB] FAIL miss hits got %0d want %0d", hit_count, hc0); end
   endtask

   task automatic test_reload;
      run_frame(200, 234, -1, 202);
      checks++; if (GUN_H !== 6'd50) begin errors++; $display("[TB] FAIL reload gun_h got %0d want 50", GUN_H); end
      checks++; if (GUN_V !== 6'd50) begin errors++; $display("[TB] FAIL reload gun_v got %0d want 50", GUN_V); end
      checks++; if (VALID !== 1'b1) begin errors++; $display("[TB] FAIL reload valid got %b want 1", VALID); end
      vblank(4);
   endtask

   task automatic test_reset_midframe;
      int hc0;
      VDE = 1'b1;
      tick(); tick();
      run_line(-1, -1);
      run_line(-1, -1);
      run_line(-1, -1);
      RESET_N = 1'b0;
      #1;
      checks++; if (GUN_H !== 6'd32) begin errors++; $display("[TB] FAIL mid_reset gun_h got %0d want 32", GUN_H); end
      checks++; if (GUN_V !== 6'd32) begin errors++; $display("[TB] FAIL mid_reset gun_v got %0d want 32", GUN_V); end
      checks++; if (VALID !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset valid got %b want 0", VALID); end
      checks++; if (HIT !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset hit got %b want 0", HIT); end
      #2 RESET_N = 1'b1;
      tick();
      hc0 = hit_count;
      run_line(-1, -1);
      run_line(134, -1);
      run_line(-1, -1);
      VDE = 1'b0;
      tick(); tick();
      vblank(3);
      checks++; if (hit_count !== hc0) begin errors++; $display("[TB] FAIL post_reset hits got %0d want %0d", hit_count, hc0); end
      checks++; if (VALID !== 1'b0) begin errors++; $display("[TB] FAIL post_reset valid got %b want 0", VALID); end
      checks++; if (GUN_H !== 6'd32) begin errors++; $display("[TB] FAIL post_reset gun_h got %0d want 32", GUN_H); end
      checks++; if (GUN_V !== 6'd32) begin errors++; $display("[TB] FAIL post_reset gun_v got %0d want 32", GUN_V); end
   endtask

   initial begin
      test_reset();
      test_first_hit();
      test_smoothing();
      test_boundaries();
      test_double_sensor();
      test_blank_sensor();
      test_miss();
      test_reload();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
